// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: masked multi-channel scan sequencer for an ALE/START/OE/EOC ADC.
// Holds one result per channel in a bank readable by channel address.
module adc_scan_ctrl #(
    parameter int CONV_TIMEOUT = 64,
    parameter int EOC_BLANK    = 2,
    parameter int OE_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       single,
    input  logic [7:0] ch_mask,
    output logic       adc_ale,
    output logic       adc_start,
    output logic       adc_oe,
    output logic [2:0] adc_addr,
    input  logic [7:0] adc_data,
    input  logic       adc_eoc,
    input  logic [2:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] valid,
    output logic [7:0] tmo_flag,
    output logic       busy,
    output logic       scan_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE,
        S_START,
        S_WAIT,
        S_READ,
        S_NEXT
    } state_t;

    state_t     state;
    logic [7:0] scan_mask;
    logic [2:0] ptr;
    logic [7:0] wait_cnt;
    logic [1:0] oe_cnt;
    logic       tmo;
    logic [7:0] bank [0:7];

    logic [7:0] above;
    logic [2:0] lo_mask;
    logic [2:0] lo_above;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Channels still to visit in this scan, and first channel of a fresh scan.
    always_comb begin
        above    = scan_mask & ~((8'd2 << ptr) - 8'd1);
        lo_mask  = lowest(ch_mask);
        lo_above = lowest(above);
    end

    // Scan sequencer, registered strobes and result bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            scan_mask <= '0;
            ptr       <= '0;
            wait_cnt  <= '0;
            oe_cnt    <= '0;
            tmo       <= 1'b0;
            adc_ale   <= 1'b0;
            adc_start <= 1'b0;
            adc_oe    <= 1'b0;
            adc_addr  <= '0;
            rd_data   <= '0;
            valid     <= '0;
            tmo_flag  <= '0;
            busy      <= 1'b0;
            scan_done <= 1'b0;
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            adc_ale   <= 1'b0;
            adc_start <= 1'b0;
            scan_done <= 1'b0;
            // Read sees the pre-write value on a same-cycle store.
            rd_data   <= bank[rd_addr];
            unique case (state)
                S_IDLE: begin
                    if ((enable || single) && ch_mask != 8'h00) begin
                        scan_mask <= ch_mask;
                        ptr       <= lo_mask;
                        adc_addr  <= lo_mask;
                        adc_ale   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ALE;
                    end
                end
                S_ALE: begin
                    adc_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt >= 8'(EOC_BLANK) && adc_eoc) begin
                        tmo    <= 1'b0;
                        oe_cnt <= '0;
                        adc_oe <= 1'b1;
                        state  <= S_READ;
                    end else if (wait_cnt == 8'(CONV_TIMEOUT - 1)) begin
                        tmo    <= 1'b1;
                        oe_cnt <= '0;
                        adc_oe <= 1'b1;
                        state  <= S_READ;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_READ: begin
                    if (oe_cnt == 2'(OE_CYCLES - 1)) begin
                        bank[ptr]     <= adc_data;
                        valid[ptr]    <= 1'b1;
                        tmo_flag[ptr] <= tmo;
                        adc_oe        <= 1'b0;
                        scan_done     <= (above == 8'h00);
                        state         <= S_NEXT;
                    end else begin
                        oe_cnt <= oe_cnt + 2'd1;
                    end
                end
                S_NEXT: begin
                    if (above != 8'h00) begin
                        ptr      <= lo_above;
                        adc_addr <= lo_above;
                        adc_ale  <= 1'b1;
                        state    <= S_ALE;
                    end else if (enable && ch_mask != 8'h00) begin
                        scan_mask <= ch_mask;
                        ptr       <= lo_mask;
                        adc_addr  <= lo_mask;
                        adc_ale   <= 1'b1;
                        state     <= S_ALE;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: scoreboard bench for adc_scan_ctrl.
// Expected channel order is queued per test and popped on each adc_ale.
module tb_adc_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       single;
    logic [7:0] ch_mask;
    logic       adc_ale;
    logic       adc_start;
    logic       adc_oe;
    logic [2:0] adc_addr;
    logic [7:0] adc_data;
    logic       adc_eoc;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] valid;
    logic [7:0] tmo_flag;
    logic       busy;
    logic       scan_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int eoc_mode = 1;
    int wpos = 1000;
    int start_cyc = 0;
    int done_cnt = 0;
    logic prev_oe = 1'b0;
    logic [7:0] data_off = 8'h00;
    logic data_ovr_en = 1'b0;
    logic [7:0] data_ovr = 8'h00;

    int exp_q[$];
    int ale_cyc[$];
    int done_cyc[$];
    int wlen_q[$];

    adc_scan_ctrl dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .single(single),
        .ch_mask(ch_mask),
        .adc_ale(adc_ale),
        .adc_start(adc_start),
        .adc_oe(adc_oe),
        .adc_addr(adc_addr),
        .adc_data(adc_data),
        .adc_eoc(adc_eoc),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .valid(valid),
        .tmo_flag(tmo_flag),
        .busy(busy),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // ADC model: result = ch*16+3 (+offset), or a fixed override.
    always_comb begin
        adc_data = data_ovr_en ? data_ovr : ({1'b0, adc_addr, 4'h3} + data_off);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard on ALE, strobe exclusivity, WAIT length, EOC drive.
    always @(negedge clk) begin
        if (adc_ale) begin
            ale_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_ale: got ch=%0d, required no conversion", adc_addr);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (adc_addr !== 3'(e)) begin
                    failures++;
                    $display("FAIL sb_ale: got ch=%0d, required ch=%0d", adc_addr, e);
                end
            end
        end
        if (adc_ale || adc_start || adc_oe) begin
            checks++;
            if (int'(adc_ale) + int'(adc_start) + int'(adc_oe) > 1) begin
                failures++;
                $display("FAIL strobe_excl: ale=%b start=%b oe=%b, required one", adc_ale, adc_start, adc_oe);
            end
        end
        if (adc_start) begin
            start_cyc = cyc;
            wpos = -1;
        end else begin
            wpos++;
        end
        if (adc_oe && !prev_oe) wlen_q.push_back(cyc - start_cyc - 1);
        prev_oe = adc_oe;
        if (scan_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        case (eoc_mode)
            0: adc_eoc = 1'b0;
            2: adc_eoc = (wpos == 0 || wpos == 1);
            3: adc_eoc = (wpos >= 2);
            default: adc_eoc = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_single(output int c);
        single = 1'b1;
        c = cyc;
        tick();
        single = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        rd_addr = a;
        tick();
        v = rd_data;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL %s_bound: scan_done count %0d, required %0d", name, done_cnt, target);
        end
    endtask

    task automatic wait_oe(input int budget, input string name);
        int n;
        n = 0;
        while (!adc_oe && n < budget) begin
            tick();
            n++;
        end
        if (!adc_oe) begin
            checks++;
            failures++;
            $display("FAIL %s_bound: adc_oe never rose within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        single = 1'b0;
        ch_mask = 8'h00;
        rd_addr = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({adc_ale, adc_start, adc_oe, busy, scan_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b, required 00000", {adc_ale, adc_start, adc_oe, busy, scan_done});
        end
        checks++;
        if (adc_addr !== 3'd0) begin
            failures++;
            $display("FAIL reset_addr: got %0d, required 0", adc_addr);
        end
        checks++;
        if (valid !== 8'h00 || tmo_flag !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: valid=%h tmo=%h, required 00 00", valid, tmo_flag);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd: got %h, required 00", rd_data);
        end
    endtask

    task automatic test_single();
        int c0, base;
        logic [7:0] v;
        ale_cyc.delete();
        done_cyc.delete();
        eoc_mode = 1;
        data_off = 8'h00;
        ch_mask = 8'h05;
        exp_q.push_back(0);
        exp_q.push_back(2);
        base = done_cnt;
        pulse_single(c0);
        wait_done(base + 1, 60, "single");
        checks++;
        if (ale_cyc.size() != 2 || ale_cyc[0] != c0 + 1 || ale_cyc[1] != c0 + 9) begin
            failures++;
            $display("FAIL single_ale_cyc: n=%0d first=%0d second=%0d, required 2 %0d %0d",
                     ale_cyc.size(), ale_cyc.size() > 0 ? ale_cyc[0] - c0 : -1,
                     ale_cyc.size() > 1 ? ale_cyc[1] - c0 : -1, 1, 9);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != c0 + 16) begin
            failures++;
            $display("FAIL single_done_cyc: got %0d, required 16",
                     done_cyc.size() > 0 ? done_cyc[0] - c0 : -1);
        end
        checks++;
        if (valid !== 8'h05 || tmo_flag !== 8'h00) begin
            failures++;
            $display("FAIL single_flags: valid=%h tmo=%h, required 05 00", valid, tmo_flag);
        end
        rd(3'd2, v);
        checks++;
        if (v !== 8'h23) begin
            failures++;
            $display("FAIL single_rd2: got %h, required 23", v);
        end
        rd(3'd0, v);
        checks++;
        if (v !== 8'h03) begin
            failures++;
            $display("FAIL single_rd0: got %h, required 03", v);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_continuous();
        int base;
        done_cyc.delete();
        eoc_mode = 1;
        for (int s = 0; s < 2; s++) begin
            for (int ch = 0; ch < 8; ch++) exp_q.push_back(ch);
        end
        exp_q.push_back(7);
        exp_q.push_back(7);
        base = done_cnt;
        ch_mask = 8'hFF;
        enable = 1'b1;
        wait_done(base + 1, 100, "cont1");
        ch_mask = 8'h80;
        wait_done(base + 2, 100, "cont2");
        checks++;
        if (done_cyc.size() < 2 || done_cyc[1] - done_cyc[0] != 64) begin
            failures++;
            $display("FAIL cont_period: got %0d, required 64",
                     done_cyc.size() > 1 ? done_cyc[1] - done_cyc[0] : -1);
        end
        wait_done(base + 3, 100, "cont3");
        checks++;
        if (done_cyc.size() < 3 || done_cyc[2] - done_cyc[1] != 8) begin
            failures++;
            $display("FAIL cont_mask7: got %0d, required 8",
                     done_cyc.size() > 2 ? done_cyc[2] - done_cyc[1] : -1);
        end
        enable = 1'b0;
        wait_done(base + 4, 40, "cont4");
        repeat (20) tick();
        checks++;
        if (done_cnt != base + 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop: scans=%0d busy=%b, required %0d 0", done_cnt - base, busy, 4);
        end
        checks++;
        if (exp_q.size() != 0 || valid !== 8'hFF) begin
            failures++;
            $display("FAIL cont_left: pending=%0d valid=%h, required 0 ff", exp_q.size(), valid);
        end
    endtask

    task automatic test_timeout();
        int c0, base;
        logic [7:0] v;
        for (int k = 0; k < 2; k++) begin
            wlen_q.delete();
            eoc_mode = (k == 0) ? 0 : 1;
            data_off = (k == 0) ? 8'h40 : 8'h00;
            ch_mask = 8'h02;
            exp_q.push_back(1);
            base = done_cnt;
            pulse_single(c0);
            wait_done(base + 1, 150, "tmo");
            checks++;
            if (wlen_q.size() != 1 || wlen_q[0] != (k == 0 ? 64 : 3)) begin
                failures++;
                $display("FAIL tmo_wait%0d: got %0d, required %0d", k,
                         wlen_q.size() > 0 ? wlen_q[0] : -1, k == 0 ? 64 : 3);
            end
            checks++;
            if (tmo_flag !== (k == 0 ? 8'h02 : 8'h00)) begin
                failures++;
                $display("FAIL tmo_flag%0d: got %h, required %h", k, tmo_flag, k == 0 ? 8'h02 : 8'h00);
            end
            rd(3'd1, v);
            checks++;
            if (v !== (k == 0 ? 8'h53 : 8'h13)) begin
                failures++;
                $display("FAIL tmo_rd%0d: got %h, required %h", k, v, k == 0 ? 8'h53 : 8'h13);
            end
        end
        data_off = 8'h00;
    endtask

    task automatic test_eoc_blank();
        int c0, base;
        for (int k = 0; k < 2; k++) begin
            wlen_q.delete();
            eoc_mode = (k == 0) ? 2 : 3;
            ch_mask = 8'h02;
            exp_q.push_back(1);
            base = done_cnt;
            pulse_single(c0);
            wait_done(base + 1, 150, "blank");
            checks++;
            if (wlen_q.size() != 1 || wlen_q[0] != (k == 0 ? 64 : 3)) begin
                failures++;
                $display("FAIL blank_wait%0d: got %0d, required %0d", k,
                         wlen_q.size() > 0 ? wlen_q[0] : -1, k == 0 ? 64 : 3);
            end
            checks++;
            if (tmo_flag[1] !== (k == 0)) begin
                failures++;
                $display("FAIL blank_flag%0d: got %b, required %b", k, tmo_flag[1], k == 0);
            end
        end
        eoc_mode = 1;
    endtask

    task automatic test_single_busy();
        int c0, base;
        logic seen;
        eoc_mode = 1;
        ch_mask = 8'h01;
        exp_q.push_back(0);
        base = done_cnt;
        pulse_single(c0);
        repeat (3) tick();
        pulse_single(c0);
        wait_done(base + 1, 40, "sbusy");
        repeat (20) tick();
        checks++;
        if (done_cnt != base + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sbusy_extra: scans=%0d busy=%b, required 1 0", done_cnt - base, busy);
        end
        ch_mask = 8'h00;
        pulse_single(c0);
        seen = 1'b0;
        repeat (6) begin
            seen = seen | busy;
            tick();
        end
        checks++;
        if (seen !== 1'b0 || done_cnt != base + 1) begin
            failures++;
            $display("FAIL smask0: busy_seen=%b scans=%0d, required 0 1", seen, done_cnt - base);
        end
    endtask

    task automatic test_rst_read();
        int c0, base;
        eoc_mode = 1;
        ch_mask = 8'h08;
        exp_q.push_back(3);
        base = done_cnt;
        pulse_single(c0);
        wait_oe(30, "rstrd");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({adc_ale, adc_start, adc_oe, busy, scan_done} !== 5'b0 || adc_addr !== 3'd0) begin
            failures++;
            $display("FAIL rstrd_ctl: got %b addr=%0d, required 00000 0",
                     {adc_ale, adc_start, adc_oe, busy, scan_done}, adc_addr);
        end
        checks++;
        if (valid !== 8'h00 || tmo_flag !== 8'h00 || rd_data !== 8'h00) begin
            failures++;
            $display("FAIL rstrd_flags: valid=%h tmo=%h rd=%h, required 00 00 00", valid, tmo_flag, rd_data);
        end
        rd_addr = 3'd3;
        repeat (20) tick();
        checks++;
        if (rd_data !== 8'h00 || done_cnt != base) begin
            failures++;
            $display("FAIL rstrd_after: rd=%h scans=%0d, required 00 0", rd_data, done_cnt - base);
        end
    endtask

    task automatic test_collision();
        int c0, base;
        logic [7:0] v;
        eoc_mode = 1;
        data_ovr_en = 1'b1;
        data_ovr = 8'h11;
        ch_mask = 8'h08;
        exp_q.push_back(3);
        base = done_cnt;
        pulse_single(c0);
        wait_done(base + 1, 40, "coll1");
        rd(3'd3, v);
        checks++;
        if (v !== 8'h11) begin
            failures++;
            $display("FAIL coll_old: got %h, required 11", v);
        end
        data_ovr = 8'hA5;
        exp_q.push_back(3);
        pulse_single(c0);
        wait_oe(30, "coll");
        tick();
        tick();
        checks++;
        if (rd_data !== 8'h11) begin
            failures++;
            $display("FAIL coll_same: got %h, required 11", rd_data);
        end
        tick();
        checks++;
        if (rd_data !== 8'hA5) begin
            failures++;
            $display("FAIL coll_next: got %h, required a5", rd_data);
        end
        wait_done(base + 2, 20, "coll2");
        data_ovr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        single = 1'b0;
        ch_mask = 8'h00;
        rd_addr = 3'd0;
        adc_eoc = 1'b0;
        test_reset();
        test_single();
        test_continuous();
        test_timeout();
        test_eoc_blank();
        test_single_busy();
        test_rst_read();
        test_collision();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d conversions never seen", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Controller that sits directly upstream of the 8-channel ADC bench model (ALE/START/OE/EOC interface, 3-bit mux address, 8-bit data).
- Sequences conversions across a masked set of channels: address latch, start pulse, wait for EOC or timeout, then output-enable readout.
- Stores one result per channel in a result bank that the 8048-side bench logic reads by channel address.
- Supports continuous scan and single-shot scan.

Parameters:
- CONV_TIMEOUT, 64: maximum WAIT cycles before a forced readout; legal range 4..255.
- EOC_BLANK, 2: WAIT cycles during which adc_eoc is ignored after START.
- OE_CYCLES, 2: cycles adc_oe is held high; data is sampled on the last of them; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  continuous scan request.
- single  in  1  one-cycle pulse; requests one full scan.
- ch_mask  in  8  per-channel enable; bit n selects channel n.
- adc_ale  out  1  address latch strobe to ADC.
- adc_start  out  1  conversion start strobe.
- adc_oe  out  1  ADC output enable.
- adc_addr  out  3  ADC mux channel select.
- adc_data  in  8  ADC conversion result.
- adc_eoc  in  1  end of conversion; high = done.
- rd_addr  in  3  result bank read address.
- rd_data  out  8  result for rd_addr, registered, 1-cycle latency.
- valid  out  8  bit n set once channel n has been stored since reset.
- tmo_flag  out  8  bit n = last store of channel n was a timeout.
- busy  out  1  high in any state other than IDLE.
- scan_done  out  1  one-cycle pulse at the end of each scan.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; result bank cleared to 8'h00; valid=0; tmo_flag=0; channel pointer=0; pending single cleared.
- States: IDLE, ALE, START, WAIT, READ, NEXT.
- IDLE:
  - Scan begins when (enable=1 or single=1) and ch_mask!=0.
  - ch_mask is latched into scan_mask at scan start; mask changes mid-scan take effect on the next scan only.
  - Channel pointer is set to the lowest set bit of scan_mask; next state is ALE.
  - single with ch_mask=0 is dropped.
- ALE (1 cycle): adc_ale=1, adc_addr=pointer. adc_addr holds through READ.
- START (1 cycle): adc_start=1.
- WAIT:
  - wait_cnt clears on entry and increments each cycle.
  - Exit to READ when wait_cnt>=EOC_BLANK and adc_eoc=1; the timeout flag clears.
  - Otherwise exit to READ when wait_cnt==CONV_TIMEOUT-1; the timeout flag sets.
  - If both conditions hold in the same cycle, it is an EOC exit (flag clear).
- READ:
  - adc_oe=1 for OE_CYCLES cycles.
  - On the last cycle, adc_data is written to result[pointer], valid[pointer] is set, and tmo_flag[pointer] takes the timeout flag.
- NEXT (1 cycle):
  - Pointer advances to the next higher set bit of scan_mask.
  - If there is none, scan_done=1 for this cycle. Then, if enable=1, a new scan starts (re-latch ch_mask, go to ALE at the lowest set bit; if ch_mask=0, go to IDLE). Otherwise go to IDLE.
- Per-channel latency with adc_eoc held high and default parameters: 1+1+3+2+1 = 8 cycles.
- single while busy: ignored, no queuing.
- enable dropped mid-scan: the current scan completes, then IDLE.
- Strobes (adc_ale, adc_start, adc_oe) are mutually exclusive and registered; there are no combinational outputs.
- Read/write collision: when rd_addr equals the channel being written in the same cycle, rd_data returns the pre-write value. The new value is visible one cycle later.
- rst mid-conversion: strobes drop at the next edge and all state clears; the ADC is not otherwise notified.

Test Plan:
- rst, then single pulse, ch_mask=8'h05, adc_eoc=1, adc_data=ch*16+3:
  - Channels 0 and 2 converted; adc_ale seen at cycle 1 and cycle 9.
  - scan_done at cycle 16; valid=8'h05; tmo_flag=0.
  - rd_addr=2 gives rd_data=8'h23 one cycle later; busy returns 0.
- enable=1, ch_mask=8'hFF, adc_eoc=1:
  - scan_done pulses every 64 cycles; adc_addr steps 0..7 and wraps.
  - Change ch_mask to 8'h80 mid-scan: only channel 7 appears in the following scans.
- adc_eoc=0, single, ch_mask=8'h02:
  - WAIT lasts exactly 64 cycles; result[1]=adc_data; tmo_flag=8'h02.
  - Repeat with adc_eoc=1: tmo_flag bit 1 clears.
- EOC blanking:
  - adc_eoc=1 only during WAIT cycles 0-1 → ignored, ends in timeout.
  - adc_eoc=1 from WAIT cycle 2 → exit after 3 WAIT cycles.
- Corner cases:
  - single during busy → no extra scan.
  - single with ch_mask=0 → busy stays 0.
  - rst asserted during READ → all outputs 0, valid=0, rd_data=8'h00 next cycle.
- Collision: rd_addr=3 held while channel 3 stores new value 8'hA5 over old value 8'h11 → rd_data=8'h11, then 8'hA5 on the following cycle.
